// File: rtl/fpu_sqrt_ctrl.sv
// Two-requester round-robin controller around a combinational SqrtFPU datapath.
// Define SQRT_CTRL_SPECIAL_BYPASS_EN to answer special operands without the settle wait.
module SqrtFPU (
  input  logic [31:0] A,
  output logic [31:0] result,
  output logic        overflow,
  output logic        underflow,
  output logic        exception
);
  logic        sgn;
  logic [7:0]  ex;
  logic [22:0] fr;
  logic [47:0] rad;
  logic [49:0] rem;
  logic [23:0] root;
  logic [24:0] rnd;
  logic [8:0]  er;
  logic [31:0] norm;

  assign sgn = A[31];
  assign ex  = A[30:23];
  assign fr  = A[22:0];

  // Odd biased exponent means an even true exponent, so the mantissa
  // is not pre-doubled; either way the root comes out in [2^23, 2^24].
  always_comb begin
    rad  = ex[0] ? {1'b0, 1'b1, fr, 23'b0} : {1'b1, fr, 24'b0};
    rem  = '0;
    root = '0;
    for (int i = 23; i >= 0; i--) begin
      rem = {rem[47:0], rad[2*i +: 2]};
      if (rem >= {24'b0, root, 2'b01}) begin
        rem  = rem - {24'b0, root, 2'b01};
        root = {root[22:0], 1'b1};
      end else begin
        root = {root[22:0], 1'b0};
      end
    end
    rnd  = {1'b0, root} + {24'b0, (rem > {26'b0, root})};
    er   = ({1'b0, ex} + 9'd126 + {8'b0, ex[0]}) >> 1;
    norm = {1'b0, er[7:0] + {7'b0, rnd[24]},
            rnd[24] ? 23'b0 : rnd[22:0]};
  end

  always_comb begin
    result    = norm;
    overflow  = 1'b0;
    underflow = 1'b0;
    exception = 1'b0;
    if (ex == 8'hff) begin
      if (fr != 23'b0 || sgn) begin
        result    = 32'h7fc00000;
        exception = 1'b1;
      end else begin
        result = 32'h7f800000;
      end
    end else if (ex == 8'h00) begin
      if (fr == 23'b0) begin
        result = A;
      end else if (sgn) begin
        result    = 32'h7fc00000;
        exception = 1'b1;
      end else begin
        result    = 32'h0;
        underflow = 1'b1;
      end
    end else if (sgn) begin
      result    = 32'h7fc00000;
      exception = 1'b1;
    end
  end
endmodule

module fpu_sqrt_ctrl #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [31:0] req0_a,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [31:0] req1_a,
  output logic        req1_ready,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_result,
  output logic        rsp_overflow,
  output logic        rsp_underflow,
  output logic        rsp_exception,
  output logic        busy
);
  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    DONE
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

  state_t      state;
  state_t      state_n;
  logic        ptr;
  logic        grant;
  logic        accept;
  logic [31:0] a_sel;
  logic [3:0]  cnt;
  logic [31:0] op_q;
  logic        id_q;
  logic [31:0] s_res;
  logic        s_ovf;
  logic        s_unf;
  logic        s_exc;
  logic        byp_hit;
  logic [31:0] byp_res;
  logic        byp_exc;

  SqrtFPU u_sqrt (
    .A         (op_q),
    .result    (s_res),
    .overflow  (s_ovf),
    .underflow (s_unf),
    .exception (s_exc)
  );

  // ptr names the requester preferred on a tie
  assign grant      = (req0_valid && req1_valid) ? ptr : req1_valid;
  assign req0_ready = (state == IDLE) && req0_valid && !grant;
  assign req1_ready = (state == IDLE) && req1_valid && grant;
  assign accept     = req0_ready || req1_ready;
  assign a_sel      = grant ? req1_a : req0_a;
  assign rsp_valid  = (state == DONE);
  assign busy       = (state != IDLE);

`ifdef SQRT_CTRL_SPECIAL_BYPASS_EN
  always_comb begin
    byp_hit = 1'b0;
    byp_res = a_sel;
    byp_exc = 1'b0;
    if (a_sel[30:0] == 31'b0) begin
      byp_hit = 1'b1;
    end else if (a_sel[31] ||
                 (a_sel[30:23] == 8'hff && a_sel[22:0] != 23'b0)) begin
      byp_hit = 1'b1;
      byp_res = 32'h7fc00000;
      byp_exc = 1'b1;
    end else if (a_sel == 32'h7f800000) begin
      byp_hit = 1'b1;
    end
  end
`else
  assign byp_hit = 1'b0;
  assign byp_res = 32'h0;
  assign byp_exc = 1'b0;
`endif

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (accept) state_n = byp_hit ? DONE : SETTLE;
      SETTLE:  if (cnt == 4'd0) state_n = DONE;
      DONE:    if (rsp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      ptr           <= 1'b0;
      op_q          <= 32'h0;
      id_q          <= 1'b0;
      cnt           <= 4'd0;
      rsp_id        <= 1'b0;
      rsp_result    <= 32'h0;
      rsp_overflow  <= 1'b0;
      rsp_underflow <= 1'b0;
      rsp_exception <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        op_q <= a_sel;
        id_q <= grant;
        cnt  <= CNT_INIT;
        ptr  <= ~grant;
        if (byp_hit) begin
          rsp_id        <= grant;
          rsp_result    <= byp_res;
          rsp_overflow  <= 1'b0;
          rsp_underflow <= 1'b0;
          rsp_exception <= byp_exc;
        end
      end else if (state == SETTLE) begin
        if (cnt != 4'd0) begin
          cnt <= cnt - 4'd1;
        end else begin
          rsp_id        <= id_q;
          rsp_result    <= s_res;
          rsp_overflow  <= s_ovf;
          rsp_underflow <= s_unf;
          rsp_exception <= s_exc;
        end
      end
    end
  end
endmodule
